// File: rtl/strm_pack.sv
// strm_pack: packs RATIO narrow input beats into one wide output word.
// A completed word that cannot leave is parked in the assembly buffer.
module strm_pack #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         i_in_dat,
    input  logic                          i_in_vld,
    input  logic                          i_in_last,
    output logic                          o_in_rdy,
    output logic [DATA_WIDTH*RATIO-1:0]   o_ot_dat,
    output logic [RATIO-1:0]              o_ot_keep,
    output logic                          o_ot_last,
    output logic                          o_ot_vld,
    input  logic                          i_ot_rdy
);

    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic {
        FILL = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t                              state_q, state_d;
    logic [RATIO-1:0][DATA_WIDTH-1:0]    asm_q, asm_d;
    logic [RATIO-1:0]                    akeep_q, akeep_d;
    logic                                alast_q, alast_d;
    logic [CW-1:0]                       cnt_q, cnt_d;
    logic                                rdy_q, rdy_d;
    logic [RATIO-1:0][DATA_WIDTH-1:0]    dat_q;
    logic [RATIO-1:0]                    keep_q;
    logic                                last_q;
    logic                                vld_q;

    logic                                in_acc;
    logic                                out_free;
    logic                                complete;
    logic                                load_new;
    logic                                load_pend;
    logic [RATIO-1:0][DATA_WIDTH-1:0]    word_dat;
    logic [RATIO-1:0]                    word_keep;

    assign in_acc   = i_in_vld && rdy_q;
    assign out_free = !vld_q || i_ot_rdy;
    assign complete = in_acc && (i_in_last || (cnt_q == CW'(RATIO - 1)));

    // The incoming beat merged into its lane; untouched lanes are already 0.
    always_comb begin
        word_dat  = asm_q;
        word_keep = akeep_q;
        for (int i = 0; i < RATIO; i++) begin
            if (cnt_q == CW'(i)) begin
                word_dat[i]  = i_in_dat;
                word_keep[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL: if (complete && !out_free) state_d = PEND;
            PEND: if (out_free) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        load_new  = 1'b0;
        load_pend = 1'b0;
        unique case (state_q)
            FILL: load_new = complete && out_free;
            PEND: load_pend = out_free;
            default: ;
        endcase
        rdy_d = (state_d == FILL);
    end

    always_comb begin
        asm_d   = asm_q;
        akeep_d = akeep_q;
        alast_d = alast_q;
        cnt_d   = cnt_q;
        if (in_acc) begin
            cnt_d = complete ? '0 : cnt_q + 1'b1;
            if (!complete || !out_free) begin
                asm_d   = word_dat;
                akeep_d = word_keep;
                alast_d = i_in_last;
            end
        end
        if (load_new || load_pend) begin
            asm_d   = '0;
            akeep_d = '0;
            alast_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            asm_q   <= '0;
            akeep_q <= '0;
            alast_q <= 1'b0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            asm_q   <= asm_d;
            akeep_q <= akeep_d;
            alast_q <= alast_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dat_q  <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
            vld_q  <= 1'b0;
        end else if (load_new) begin
            dat_q  <= word_dat;
            keep_q <= word_keep;
            last_q <= i_in_last;
            vld_q  <= 1'b1;
        end else if (load_pend) begin
            dat_q  <= asm_q;
            keep_q <= akeep_q;
            last_q <= alast_q;
            vld_q  <= 1'b1;
        end else if (i_ot_rdy) begin
            vld_q  <= 1'b0;
        end
    end

    assign o_in_rdy  = rdy_q;
    assign o_ot_dat  = dat_q;
    assign o_ot_keep = keep_q;
    assign o_ot_last = last_q;
    assign o_ot_vld  = vld_q;

endmodule

// File: tb/tb_strm_pack.sv
// tb_strm_pack: directed and random stimulus, queue-based reference
// model of beat packing, and an independent output monitor.
module tb_strm_pack;

    localparam int DW = 8;
    localparam int R  = 4;

    logic              clk;
    logic              reset;
    logic [DW-1:0]     i_in_dat;
    logic              i_in_vld;
    logic              i_in_last;
    logic              o_in_rdy;
    logic [DW*R-1:0]   o_ot_dat;
    logic [R-1:0]      o_ot_keep;
    logic              o_ot_last;
    logic              o_ot_vld;
    logic              i_ot_rdy;

    typedef struct {
        logic [DW*R-1:0] dat;
        logic [R-1:0]    keep;
        logic            last;
    } word_t;

    word_t         exp_q[$];
    logic [DW-1:0] part_q[$];

    int checks = 0;
    int errors = 0;

    logic            stall_prev;
    logic [DW*R-1:0] dat_prev;
    logic [R-1:0]    keep_prev;
    logic            last_prev;

    strm_pack #(.DATA_WIDTH(DW), .RATIO(R)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_in_dat  (i_in_dat),
        .i_in_vld  (i_in_vld),
        .i_in_last (i_in_last),
        .o_in_rdy  (o_in_rdy),
        .o_ot_dat  (o_ot_dat),
        .o_ot_keep (o_ot_keep),
        .o_ot_last (o_ot_last),
        .o_ot_vld  (o_ot_vld),
        .i_ot_rdy  (i_ot_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Reference model: collect accepted beats, emit a word at R beats or last.
    always @(negedge clk) begin
        if (reset) begin
            part_q.delete();
            exp_q.delete();
        end else if (i_in_vld && o_in_rdy) begin
            part_q.push_back(i_in_dat);
            if (part_q.size() == R || i_in_last) begin
                word_t w;
                w.dat  = '0;
                w.keep = '0;
                w.last = i_in_last;
                for (int i = 0; i < part_q.size(); i++) begin
                    w.dat  = w.dat | ((DW*R)'(part_q[i]) << (DW * i));
                    w.keep[i] = 1'b1;
                end
                exp_q.push_back(w);
                part_q.delete();
            end
        end
    end

    // Monitor: compare every output handshake and hold-under-stall.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_vld", o_ot_vld, 1'b1);
                chk("hold_dat", o_ot_dat, dat_prev);
                chk("hold_keep", o_ot_keep, keep_prev);
                chk("hold_last", o_ot_last, last_prev);
            end
            if (o_ot_vld && i_ot_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 1'b1, 1'b0);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    chk("sb_dat", o_ot_dat, w.dat);
                    chk("sb_keep", o_ot_keep, w.keep);
                    chk("sb_last", o_ot_last, w.last);
                end
            end
            stall_prev = o_ot_vld && !i_ot_rdy;
            dat_prev   = o_ot_dat;
            keep_prev  = o_ot_keep;
            last_prev  = o_ot_last;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        logic acc;
        int   n;
        i_in_dat  = d;
        i_in_last = l;
        i_in_vld  = 1'b1;
        n = 0;
        do begin
            acc = o_in_rdy;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("beat_timeout", 1'b0, 1'b1);
        i_in_vld  = 1'b0;
        i_in_last = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        i_in_dat  = '0;
        i_in_vld  = 1'b0;
        i_in_last = 1'b0;
        i_ot_rdy  = 1'b0;
        stall_prev = 1'b0;
        cycles(3);
        chk("rst_vld", o_ot_vld, 1'b0);
        chk("rst_dat", o_ot_dat, 32'h0);
        chk("rst_keep", o_ot_keep, 4'h0);
        chk("rst_last", o_ot_last, 1'b0);
        chk("rst_rdy", o_in_rdy, 1'b0);
        reset = 1'b0;
        cycles(1);
        chk("rdy_after_rst", o_in_rdy, 1'b1);

        // Full word
        i_ot_rdy = 1'b1;
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b0);
        chk("full_vld", o_ot_vld, 1'b1);
        chk("full_dat", o_ot_dat, 32'h44332211);
        chk("full_keep", o_ot_keep, 4'hF);
        chk("full_last", o_ot_last, 1'b0);

        // Short packets
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b1);
        chk("short2_dat", o_ot_dat, 32'h0000BBAA);
        chk("short2_keep", o_ot_keep, 4'h3);
        chk("short2_last", o_ot_last, 1'b1);
        send_beat(8'h5C, 1'b1);
        chk("short1_dat", o_ot_dat, 32'h0000005C);
        chk("short1_keep", o_ot_keep, 4'h1);
        chk("short1_last", o_ot_last, 1'b1);
        cycles(2);

        // Stall: second word parks in PEND
        i_ot_rdy = 1'b0;
        for (int i = 1; i <= 8; i++) send_beat(8'(i), 1'b0);
        chk("pend_rdy", o_in_rdy, 1'b0);
        chk("pend_dat0", o_ot_dat, 32'h04030201);
        cycles(2);
        chk("pend_rdy_hold", o_in_rdy, 1'b0);
        chk("pend_dat_hold", o_ot_dat, 32'h04030201);
        i_ot_rdy = 1'b1;
        cycles(1);
        chk("drain_vld1", o_ot_vld, 1'b1);
        chk("drain_dat1", o_ot_dat, 32'h08070605);
        chk("drain_rdy", o_in_rdy, 1'b1);
        cycles(1);
        chk("drain_vld_clr", o_ot_vld, 1'b0);

        // Back-to-back streaming
        for (int i = 0; i < 16; i++) begin
            send_beat(8'($urandom), 1'b0);
            chk("b2b_rdy", o_in_rdy, 1'b1);
            chk("b2b_vld", o_ot_vld, (i % 4) == 3);
        end
        cycles(2);

        // Reset mid-word
        send_beat(8'hE1, 1'b0);
        send_beat(8'hE2, 1'b0);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        chk("midrst_vld", o_ot_vld, 1'b0);
        chk("midrst_rdy", o_in_rdy, 1'b0);
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b0);
        chk("midrst_dat", o_ot_dat, 32'h44332211);
        chk("midrst_keep", o_ot_keep, 4'hF);
        cycles(2);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            i_in_vld  = ($urandom_range(0, 9) < 7);
            i_in_dat  = 8'($urandom);
            i_in_last = ($urandom_range(0, 3) == 0);
            i_ot_rdy  = ($urandom_range(0, 9) < 6);
            cycles(1);
        end
        i_in_vld  = 1'b0;
        i_in_last = 1'b0;
        i_ot_rdy  = 1'b1;
        n = 0;
        while (n < 20 && (exp_q.size() != 0 || o_ot_vld)) begin
            cycles(1);
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_final_vld", o_ot_vld, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
